// File: rtl/move_sequencer_pkg.sv
// Shared cell encodings, FSM state type and sizing helpers for the move sequencer.
package move_sequencer_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_X     = 2'd1;
  localparam logic [1:0] CELL_O     = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FETCH  = 3'd2,
    SUBMIT = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Bits needed to index `value` entries; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/move_script_ram.sv
// Script storage: DEPTH entries of {cell index, cell value}, synchronous write, asynchronous read.
module move_script_ram
  import move_sequencer_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int DW    = 6,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/move_sequencer.sv
// Replays a loaded move script into a board: clear pulse, then one submit/response handshake per move.
// IDLE wait for start | CLEAR board_reset pulse | FETCH read entry | SUBMIT strobe, await response | GAP spacing | FINISH done pulse
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter  int SIDE           = 3,
  parameter  int DEPTH          = 16,
  parameter  int RESET_CYCLES   = 2,
  parameter  int SUBMIT_MIN     = 1,
  parameter  int GAP_CYCLES     = 1,
  parameter  int TIMEOUT        = 15,
  parameter  int STOP_ON_REJECT = 1,
  localparam int IW             = clog2(SIDE * SIDE),
  localparam int AW             = clog2(DEPTH),
  localparam int NW             = AW + 1,
  localparam int CW             = clog2(max4(RESET_CYCLES, SUBMIT_MIN, GAP_CYCLES, TIMEOUT) + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [IW-1:0] i_load_loc,
  input  logic [1:0]    i_load_val,
  input  logic [NW-1:0] i_num_moves,
  input  logic          i_start,
  input  logic          i_accept,
  input  logic          i_reject,
  output logic          o_board_reset,
  output logic [IW-1:0] o_update_loc,
  output logic [1:0]    o_update_val,
  output logic          o_submit,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [NW-1:0] o_moves_played
);

  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [NW-1:0] r_ptr, r_n, r_moves;
  logic [IW-1:0] r_loc;
  logic [1:0]    r_val;
  logic          r_busy, r_error, r_got, r_rej;

  logic [IW+1:0] w_rd_data;
  logic [CW:0]   w_high;
  logic [NW-1:0] w_ptr_nx, w_n_start;
  logic          w_we, w_resp_now, w_have, w_rej, w_min_ok, w_timeout, w_leave, w_stop;

  assign w_we = i_load_en && (r_state == IDLE);

  move_script_ram #(.DEPTH(DEPTH), .DW(IW + 2)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (i_load_addr),
    .i_wdata ({i_load_loc, i_load_val}),
    .i_raddr (r_ptr[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // r_cnt counts completed SUBMIT cycles, so w_high is how long submit has been up including now.
  assign w_high     = {1'b0, r_cnt} + 1'b1;
  assign w_resp_now = i_accept | i_reject;
  assign w_have     = r_got | w_resp_now;
  assign w_rej      = r_got ? r_rej : i_reject;
  assign w_min_ok   = (w_high >= (CW + 1)'(SUBMIT_MIN));
  assign w_timeout  = !w_have && (w_high == (CW + 1)'(TIMEOUT));
  assign w_leave    = w_have && w_min_ok;
  assign w_stop     = w_rej && (STOP_ON_REJECT != 0);
  assign w_ptr_nx   = r_ptr + 1'b1;
  assign w_n_start  = (i_num_moves > NW'(DEPTH)) ? NW'(DEPTH) : i_num_moves;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:   if (i_start) w_state_nx = CLEAR;
      CLEAR:  if (r_cnt == '0) w_state_nx = (r_n == '0) ? FINISH : FETCH;
      FETCH:  w_state_nx = SUBMIT;
      SUBMIT: begin
        if (w_timeout || (w_leave && w_stop)) w_state_nx = FINISH;
        else if (w_leave) begin
          if (GAP_CYCLES > 0) w_state_nx = GAP;
          else                w_state_nx = (w_ptr_nx == r_n) ? FINISH : FETCH;
        end
      end
      GAP:    if (r_cnt == '0) w_state_nx = (r_ptr == r_n) ? FINISH : FETCH;
      FINISH: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_board_reset = 1'b0;
    o_submit      = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      CLEAR:   o_board_reset = 1'b1;
      SUBMIT:  o_submit      = 1'b1;
      FINISH:  o_done        = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_n     <= '0;
      r_moves <= '0;
      r_loc   <= '0;
      r_val   <= CELL_EMPTY;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
      r_got   <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_n     <= w_n_start;
          r_ptr   <= '0;
          r_moves <= '0;
          r_error <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= CW'(RESET_CYCLES - 1);
        end
        CLEAR: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        FETCH: begin
          {r_loc, r_val} <= w_rd_data;
          r_cnt          <= '0;
          r_got          <= 1'b0;
          r_rej          <= 1'b0;
        end
        SUBMIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_got && w_resp_now) begin
            r_got <= 1'b1;
            r_rej <= i_reject;
          end
          if (w_timeout) r_error <= 1'b1;
          else if (w_leave) begin
            if (w_rej) r_error <= 1'b1;
            else       r_moves <= r_moves + 1'b1;
            r_ptr <= w_ptr_nx;
            r_cnt <= CW'(GAP_LOAD);
          end
        end
        GAP: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        FINISH: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_update_loc   = r_loc;
  assign o_update_val   = r_val;
  assign o_busy         = r_busy;
  assign o_error        = r_error;
  assign o_moves_played = r_moves;

endmodule
